aes_ex_word_unit: RTL and testbench

- EX-stage consumer of the AES fields launched by the ID/EX pipeline register: enable, word-write flag, key size, mode, data word, word index and auto-increment.
- Collects 32-bit key and plaintext/ciphertext words into local buffers.
- Launches the AES core with a start/done handshake, latches the 128-bit result, and returns result words to the pipeline.
- Drives `stall_o` back to hazard control while the core is busy.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_ex_word_unit_if.sv | 36 +++
 rtl/aes_word_buffer.sv | 50 +++++
 rtl/aes_ex_word_unit.sv | 145 ++++++++++++++
 tb/tb_aes_ex_word_unit.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES EX-stage word unit.
// Optional key/block zeroize after completion is selected by AES_KEY_ZEROIZE_EN.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } aes_state_t;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  localparam logic [1:0] MODE_ENC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_RSVD = 2'b10;
  localparam logic [1:0] MODE_READ = 2'b11;

  // Word-index map of the write buffer: key words first, then block words.
  localparam int KEY_IDX_BASE = 0;
  localparam int BLK_IDX_BASE = 8;

  typedef struct packed {
    aes_state_t state;
    logic       result_valid;
    logic [1:0] rptr;
  } aes_dbg_t;

  // The reserved key-size code behaves as a 128-bit key.
  function automatic logic [1:0] norm_key_size(input logic [1:0] ks);
    logic [1:0] r;
    case (ks)
      KS_128, KS_192, KS_256: r = ks;
      default:                r = KS_128;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_ex_word_unit_if.sv
// Core-side bus between the AES EX word unit (master) and the AES core (slave).
interface aes_ex_word_unit_if;

  // Handshake: core_start_o is a one-cycle request pulse; key, block, mode and
  // key size are stable from that pulse until core_done_i. core_done_i is a
  // one-cycle completion pulse qualifying core_result_i. There is no backpressure:
  // the master is always ready for done while waiting, and ignores it otherwise.
  logic         core_start_o;
  logic         core_mode_o;
  logic [1:0]   core_key_size_o;
  logic [255:0] core_key_o;
  logic [127:0] core_block_o;
  logic         core_done_i;
  logic [127:0] core_result_i;

  modport master (
    output core_start_o,
    output core_mode_o,
    output core_key_size_o,
    output core_key_o,
    output core_block_o,
    input  core_done_i,
    input  core_result_i
  );

  modport slave (
    input  core_start_o,
    input  core_mode_o,
    input  core_key_size_o,
    input  core_key_o,
    input  core_block_o,
    output core_done_i,
    output core_result_i
  );

endinterface

// File: rtl/aes_word_buffer.sv
// Indexed 32-bit write buffer holding the AES key words and block words,
// with a synchronous clear used for zeroize.
module aes_word_buffer
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = 8,
  parameter int BLK_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [3:0]                wr_idx,
  input  logic [31:0]               wr_data,
  input  logic                      zeroize,
  output logic [KEY_WORDS*32-1:0]   key_o,
  output logic [BLK_WORDS*32-1:0]   block_o
);

  logic [31:0] key_q [KEY_WORDS];
  logic [31:0] blk_q [BLK_WORDS];
  logic [31:0] idx_ext;

  assign idx_ext = {28'd0, wr_idx};

  // Indices outside both windows match no word and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
      for (int k = 0; k < BLK_WORDS; k++) blk_q[k] <= '0;
    end else if (zeroize) begin
      for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
      for (int k = 0; k < BLK_WORDS; k++) blk_q[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < KEY_WORDS; k++) begin
        if (idx_ext == 32'(KEY_IDX_BASE + k)) key_q[k] <= wr_data;
      end
      for (int k = 0; k < BLK_WORDS; k++) begin
        if (idx_ext == 32'(BLK_IDX_BASE + k)) blk_q[k] <= wr_data;
      end
    end
  end

  always_comb begin
    key_o   = '0;
    block_o = '0;
    for (int k = 0; k < KEY_WORDS; k++) key_o[k*32 +: 32] = key_q[k];
    for (int k = 0; k < BLK_WORDS; k++) block_o[k*32 +: 32] = blk_q[k];
  end

endmodule

// File: rtl/aes_ex_word_unit.sv
// EX-stage AES word unit: buffers key/block words, launches the core, latches
// and returns result words, stalls the pipeline while busy. Macro: AES_KEY_ZEROIZE_EN.
module aes_ex_word_unit
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = 8,
  parameter int BLK_WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                enable_aes_i,
  input  logic                aes_w_i,
  input  logic [1:0]          key_size_i,
  input  logic [1:0]          mode_aes_i,
  input  logic [31:0]         w2_i,
  input  logic [31:0]         re_adder_32_i,
  input  logic                plus1_i,
  aes_ex_word_unit_if.master  core,
  output logic [31:0]         rdata_o,
  output logic                rdata_valid_o,
  output logic                stall_o,
  output logic                busy_o,
  output aes_dbg_t            dbg_o
);

  aes_state_t   state_q, state_d;
  logic         mode_q;
  logic [1:0]   ks_q;
  logic [127:0] result_q;
  logic         result_valid_q;
  logic [1:0]   rptr_q;

  logic         accept;
  logic         op_write, op_launch, op_read;
  logic         start_d;
  logic         done_in_wait;
  logic         zeroize;
  logic [1:0]   rd_idx;
  logic [31:0]  rd_word;
  logic         unused_idx_bits;

  assign unused_idx_bits = ^re_adder_32_i[31:4];

  assign busy_o  = (state_q != IDLE);
  assign stall_o = valid_i & enable_aes_i & busy_o;
  assign accept  = valid_i & enable_aes_i & ~stall_o;

  always_comb begin
    op_write  = 1'b0;
    op_launch = 1'b0;
    op_read   = 1'b0;
    if (accept) begin
      if (aes_w_i) begin
        op_write = 1'b1;
      end else begin
        case (mode_aes_i)
          MODE_ENC, MODE_DEC: op_launch = 1'b1;
          MODE_READ:          op_read   = 1'b1;
          MODE_RSVD:          ;
          default:            ;
        endcase
      end
    end
  end

  // Done only counts while waiting; stray pulses in other states are dropped.
  assign done_in_wait = (state_q == WAIT) & core.core_done_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      IDLE:    if (op_launch) state_d = LAUNCH;
      LAUNCH: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT:    if (core.core_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q         <= 1'b0;
      ks_q           <= KS_128;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      rptr_q         <= 2'd0;
    end else begin
      if (op_launch) begin
        mode_q         <= mode_aes_i[0];
        ks_q           <= norm_key_size(key_size_i);
        result_valid_q <= 1'b0;
      end
      if (done_in_wait) begin
        result_q       <= core.core_result_i;
        result_valid_q <= 1'b1;
        rptr_q         <= 2'd0;
      end else if (op_read && plus1_i) begin
        rptr_q <= rptr_q + 2'd1;
      end
    end
  end

`ifdef AES_KEY_ZEROIZE_EN
  assign zeroize = done_in_wait;
`else
  assign zeroize = 1'b0;
`endif

  aes_word_buffer #(
    .KEY_WORDS (KEY_WORDS),
    .BLK_WORDS (BLK_WORDS)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (op_write),
    .wr_idx  (re_adder_32_i[3:0]),
    .wr_data (w2_i),
    .zeroize (zeroize),
    .key_o   (core.core_key_o),
    .block_o (core.core_block_o)
  );

  assign core.core_start_o    = start_d;
  assign core.core_mode_o     = mode_q;
  assign core.core_key_size_o = ks_q;

  assign rd_idx        = plus1_i ? rptr_q : re_adder_32_i[1:0];
  assign rd_word       = result_q[{rd_idx, 5'd0} +: 32];
  assign rdata_valid_o = op_read & result_valid_q;
  assign rdata_o       = rdata_valid_o ? rd_word : 32'd0;

  assign dbg_o.state        = state_q;
  assign dbg_o.result_valid = result_valid_q;
  assign dbg_o.rptr         = rptr_q;

endmodule

// File: tb/tb_aes_ex_word_unit.sv
// Bench for aes_ex_word_unit: behavioural AES core, buffer model and a
// read-data scoreboard.
module tb_aes_ex_word_unit;
  import aes_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid_i, enable_aes_i, aes_w_i, plus1_i;
  logic [1:0]  key_size_i, mode_aes_i;
  logic [31:0] w2_i, re_adder_32_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, stall_o, busy_o;
  aes_dbg_t    dbg_o;

  aes_ex_word_unit_if core_if ();

  aes_ex_word_unit dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .enable_aes_i  (enable_aes_i),
    .aes_w_i       (aes_w_i),
    .key_size_i    (key_size_i),
    .mode_aes_i    (mode_aes_i),
    .w2_i          (w2_i),
    .re_adder_32_i (re_adder_32_i),
    .plus1_i       (plus1_i),
    .core          (core_if.master),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .stall_o       (stall_o),
    .busy_o        (busy_o),
    .dbg_o         (dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters, scoreboard, models ----------------
  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  m_key [8];
  logic [31:0]  m_blk [4];
  logic [127:0] cur_result;
  int           core_delay = 10;
  bit           core_auto = 1'b1;
  int           kick_req = 0;
  int           kick_ack = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_key();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = m_key[k];
    return r;
  endfunction

  function automatic logic [127:0] pack_blk();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = m_blk[k];
    return r;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d);
    if (idx < 8)       m_key[idx] = d;
    else if (idx < 12) m_blk[idx-8] = d;
  endtask

  task automatic model_done();
`ifdef AES_KEY_ZEROIZE_EN
    for (int k = 0; k < 8; k++) m_key[k] = '0;
    for (int k = 0; k < 4; k++) m_blk[k] = '0;
`endif
  endtask

  // Behavioural AES core: done core_delay edges after the start pulse.
  initial begin
    core_if.core_done_i   = 1'b0;
    core_if.core_result_i = '0;
    forever begin
      @(negedge clk);
      if (core_if.core_start_o) start_cnt++;
      if (core_if.core_start_o && core_auto) begin
        repeat (core_delay) @(posedge clk);
        #1;
        core_if.core_done_i   = 1'b1;
        core_if.core_result_i = cur_result;
        @(posedge clk);
        #1;
        core_if.core_done_i   = 1'b0;
        core_if.core_result_i = '0;
      end else if (kick_req != kick_ack) begin
        kick_ack = kick_req;
        @(posedge clk);
        #1;
        core_if.core_done_i   = 1'b1;
        core_if.core_result_i = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        core_if.core_done_i   = 1'b0;
        core_if.core_result_i = '0;
      end
    end
  end

  // Read-data scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rdata_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1'b1, 1'b0);
        end else begin
          check("rd_data", rdata_o, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_i = 0; enable_aes_i = 0; aes_w_i = 0; plus1_i = 0;
    key_size_i = 0; mode_aes_i = 0; w2_i = 0; re_adder_32_i = 0;
  endtask

  task automatic do_write(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    valid_i = 1; enable_aes_i = 1; aes_w_i = 1;
    re_adder_32_i = 32'(idx); w2_i = d;
    @(posedge clk); #1;
    drive_idle();
    model_write(idx, d);
  endtask

  task automatic do_launch(input logic [1:0] mode, input logic [1:0] ks);
    @(posedge clk); #1;
    valid_i = 1; enable_aes_i = 1; aes_w_i = 0;
    mode_aes_i = mode; key_size_i = ks;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic do_read(input bit p1, input int idx, input bit exp_v, input logic [31:0] exp_d);
    @(posedge clk); #1;
    valid_i = 1; enable_aes_i = 1; aes_w_i = 0; mode_aes_i = MODE_READ;
    plus1_i = p1; re_adder_32_i = 32'(idx);
    if (exp_v) exp_q.push_back(exp_d);
    @(negedge clk);
    if (!exp_v) begin
      check("rd_inv_valid", rdata_valid_o, 1'b0);
      check("rd_inv_data", rdata_o, 32'd0);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (busy_o && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (busy_o) check("wait_idle_timeout", 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0]  key_init [4] = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
  logic [31:0]  blk_init [4] = '{32'h6BC1BEE2, 32'h2E409F96, 32'hE93D7E11, 32'h7393172A};
  logic [127:0] res1 = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
  logic [127:0] res2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int cyc;
    int hold_cyc;
    int s0;
    drive_idle();
    for (int k = 0; k < 8; k++) m_key[k] = '0;
    for (int k = 0; k < 4; k++) m_blk[k] = '0;
    cur_result = res1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", core_if.core_start_o, 1'b0);
    check("rst_key", core_if.core_key_o, 256'd0);
    check("rst_blk", core_if.core_block_o, 128'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_state", dbg_o.state, IDLE);
    check("rst_rv", dbg_o.result_valid, 1'b0);
    reset = 1'b1;

    // Read before any launch returns nothing.
    do_read(1'b1, 0, 1'b0, 32'd0);

    for (int k = 0; k < 4; k++) do_write(k, key_init[k]);
    for (int k = 0; k < 4; k++) do_write(8 + k, blk_init[k]);
    @(negedge clk);
    check("wr_key_lo", core_if.core_key_o[127:0], {key_init[3], key_init[2], key_init[1], key_init[0]});
    check("wr_key_hi", core_if.core_key_o[255:128], 128'd0);
    check("wr_blk", core_if.core_block_o, {blk_init[3], blk_init[2], blk_init[1], blk_init[0]});

    // Index 13 lies outside both windows.
    do_write(13, 32'hFFFF_FFFF);
    @(negedge clk);
    check("idx13_key", core_if.core_key_o, pack_key());
    check("idx13_blk", core_if.core_block_o, pack_blk());

    // Reserved mode: no stall, no launch.
    s0 = start_cnt;
    @(posedge clk); #1;
    valid_i = 1; enable_aes_i = 1; aes_w_i = 0; mode_aes_i = MODE_RSVD;
    @(negedge clk);
    check("rsvd_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rsvd_busy", busy_o, 1'b0);
    check("rsvd_nostart", start_cnt, s0);

    // Encrypt launch; a held write to key word 2 stalls until completion.
    s0 = start_cnt;
    core_delay = 10;
    do_launch(MODE_ENC, KS_128);
    valid_i = 1; enable_aes_i = 0; aes_w_i = 1; re_adder_32_i = 32'd2; w2_i = 32'hDEADBEEF;
    @(negedge clk);
    check("l1_start", core_if.core_start_o, 1'b1);
    check("l1_state", dbg_o.state, LAUNCH);
    check("l1_mode", core_if.core_mode_o, 1'b0);
    check("l1_ks", core_if.core_key_size_o, KS_128);
    check("l1_key", core_if.core_key_o, pack_key());
    check("l1_blk", core_if.core_block_o, pack_blk());
    check("non_aes_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    enable_aes_i = 1;
    hold_cyc = 0;
    @(negedge clk);
    while (busy_o && hold_cyc < 40) begin
      check("wait_stall", stall_o, 1'b1);
      check("wait_key2", core_if.core_key_o[95:64], m_key[2]);
      check("wait_nostart", core_if.core_start_o, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      hold_cyc++;
    end
    check("wait_cycles", hold_cyc, 10);
    check("l1_start_once", start_cnt - s0, 1);
    model_done();
    check("idle_nostall", stall_o, 1'b0);
    check("pre_wr_key", core_if.core_key_o, pack_key());
    check("pre_wr_blk", core_if.core_block_o, pack_blk());
    @(posedge clk); #1;
    drive_idle();
    model_write(2, 32'hDEADBEEF);
    @(negedge clk);
    check("post_wr_key", core_if.core_key_o, pack_key());

    // Result words, pointer wrap, direct index.
    for (int k = 0; k < 5; k++) do_read(1'b1, 0, 1'b1, res1[(k%4)*32 +: 32]);
    do_read(1'b0, 2, 1'b1, res1[95:64]);
    do_read(1'b1, 3, 1'b1, res1[63:32]);

    // Relaunch: decrypt, reserved key size, done in first WAIT cycle.
    do_write(2, key_init[2]);
    cur_result = res2;
    core_delay = 1;
    do_launch(MODE_DEC, 2'b11);
    @(negedge clk);
    check("l2_start", core_if.core_start_o, 1'b1);
    check("l2_rv_clr", dbg_o.result_valid, 1'b0);
    check("l2_mode", core_if.core_mode_o, 1'b1);
    check("l2_ks", core_if.core_key_size_o, KS_128);
    check("l2_key", core_if.core_key_o, pack_key());
    check("l2_blk", core_if.core_block_o, pack_blk());
    wait_idle(50, cyc);
    check("l2_latency", cyc, 2);
    model_done();
    check("l2_key_after", core_if.core_key_o, pack_key());
    check("l2_blk_after", core_if.core_block_o, pack_blk());
    do_read(1'b0, 3, 1'b1, res2[127:96]);
    do_read(1'b1, 0, 1'b1, res2[31:0]);

    // Reset during WAIT; a later done must be ignored.
    core_auto = 1'b0;
    do_launch(MODE_ENC, KS_256);
    @(negedge clk);
    check("l3_ks", core_if.core_key_size_o, KS_256);
    @(negedge clk);
    check("l3_wait", dbg_o.state, WAIT);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    kick_req++;
    repeat (4) @(negedge clk);
    check("mr_state", dbg_o.state, IDLE);
    check("mr_busy", busy_o, 1'b0);
    check("mr_rv", dbg_o.result_valid, 1'b0);
    check("mr_start", core_if.core_start_o, 1'b0);
    check("mr_mode", core_if.core_mode_o, 1'b0);
    check("mr_ks", core_if.core_key_size_o, 2'b00);
    check("mr_key", core_if.core_key_o, 256'd0);
    check("mr_blk", core_if.core_block_o, 128'd0);
    check("mr_kick_seen", kick_ack, kick_req);
    do_read(1'b1, 0, 1'b0, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
